// File: rtl/reg_alu_pkg.sv
// Shared encodings for the register/ALU sequencer: ALU opcodes and FSM states.
package reg_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_XOR   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_NOR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_param.sv
// Parametrised register file: one synchronous write port, two asynchronous
// read ports and an asynchronous debug read port.
module regfile_param #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 4,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    // NOTE: start from the current contents so every path assigns mem_d; no latch.
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: non-blocking assignments for all flop updates so every register
  // samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this is a handful of flops, not an SRAM macro, so clearing it on
      // reset is cheap and makes the architectural state fully defined.
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1   = mem_q[raddr1];
  assign rdata2   = mem_q[raddr2];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/reg_alu_sequencer.sv
// Multi-cycle register/ALU execution unit: accepts one micro-op per handshake,
// sequences READ/EXEC/WB internally and reports done, result and flags.
module reg_alu_sequencer
  import reg_alu_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 4,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_alu_ctrl,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef struct packed {
    logic              load;
    alu_op_e           op;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] imm;
  } cmd_t;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              alu_ovf_q, alu_ovf_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] rd1, rd2, wb_data;
  logic              wb_we, wb_ovf, handshake;

  // Returns {overflow, value}; overflow is only meaningful for add and sub.
  function automatic logic [DATA_W:0] alu_eval(input alu_op_e op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] v;
    logic              ovf;
    v   = '0;
    ovf = 1'b0;
    case (op)
      ALU_ADD: begin
        v   = a + b;
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (v[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        v   = a - b;
        ovf = (a[DATA_W-1] != b[DATA_W-1]) && (v[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:   v = a & b;
      ALU_XOR:   v = a ^ b;
      ALU_OR:    v = a | b;
      ALU_SLT:   v = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR:   v = ~(a | b);
      ALU_PASSB: v = b;
      default:   v = b;
    endcase
    return {ovf, v};
  endfunction

  regfile_param #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .waddr    (cmd_q.dst),
    .wdata    (wb_data),
    .raddr1   (cmd_q.src1),
    .rdata1   (rd1),
    .raddr2   (cmd_q.src2),
    .rdata2   (rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = READ;
      READ:    state_d = cmd_q.load ? WB : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are masked during reset so an aborted op never signals completion.
  always_comb begin
    cmd_ready = (state_q == IDLE) && !rst;
    done      = (state_q == WB) && !rst;
    wb_we     = done;
    handshake = cmd_valid && cmd_ready;
  end

  always_comb begin
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    alu_ovf_d  = alu_ovf_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    wb_data    = cmd_q.load ? cmd_q.imm : alu_q;
    wb_ovf     = cmd_q.load ? 1'b0 : alu_ovf_q;

    if (handshake) begin
      cmd_d.load = cmd_load;
      cmd_d.op   = alu_op_e'(cmd_alu_ctrl);
      cmd_d.src1 = cmd_src1;
      cmd_d.src2 = cmd_src2;
      cmd_d.dst  = cmd_dst;
      cmd_d.imm  = cmd_imm;
    end
    if (state_q == READ) begin
      a_d = rd1;
      b_d = rd2;
    end
    if (state_q == EXEC) {alu_ovf_d, alu_d} = alu_eval(cmd_q.op, a_q, b_q);
    if (wb_we) begin
      result_d   = wb_data;
      zero_d     = (wb_data == '0);
      overflow_d = wb_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      alu_ovf_q  <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      alu_ovf_q  <= alu_ovf_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: doc/reg_alu_sequencer.md
Name: reg_alu_sequencer

Overview:
Multi-cycle register/ALU execution unit. It accepts one micro-op per handshake (ALU op or immediate load), reads two source registers, computes, and writes back to a destination register. It is the parametrised successor of the fixed 4x32 regfile-plus-ALU pairing. Command sequencing and write-enable timing move from the bench into hardware, and the block reports flags and completion.

Parameters:
DATA_W, 32, datapath and register width (>=8)
NREGS, 4, number of registers (power of 2, >=2)
ADDR_W, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_load  in  1  1 = load cmd_imm into dst; 0 = ALU op
cmd_alu_ctrl  in  3  ALU operation select
cmd_src1  in  ADDR_W  operand A register
cmd_src2  in  ADDR_W  operand B register
cmd_dst  in  ADDR_W  destination register
cmd_imm  in  DATA_W  immediate for load
done  out  1  one-cycle pulse in write-back cycle
result  out  DATA_W  value written at last write-back (held)
zero  out  1  result == 0 (held)
overflow  out  1  signed overflow of last add/sub (held)
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  combinational read of register dbg_addr

Behaviour:
- Reset: all registers = 0; state = IDLE; cmd_ready = 0 during the reset cycle; done, result, zero, overflow = 0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: cmd_ready = 1. On handshake, latch every cmd_* field and go to READ. cmd_ready = 0 in all other states.
- READ: latch A = R[src1] and B = R[src2]. For load, skip to WB.
- EXEC: register the ALU output and the overflow flag.
- WB: R[dst] <= value; update result, zero and overflow; done = 1; return to IDLE.
- Latency: handshake at edge N; ALU write-back at edge N+3; load write-back at edge N+2. done is high in the cycle ending at the write edge. Next handshake is possible at the edge after WB, so throughput is one op per 4 cycles (ALU) or 3 cycles (load).
- ALU ops, all mod 2^DATA_W:
  - 000 add
  - 001 sub (A-B)
  - 010 and
  - 011 xor
  - 100 or
  - 101 signed set-less-than (1 or 0)
  - 110 nor
  - 111 pass B
- overflow: signed rule, add: sign(A)==sign(B) && sign(sum)!=sign(A); sub: sign(A)!=sign(B) && sign(diff)!=sign(A). For all other ops and loads, overflow = 0.
- zero is computed on the written value for both ALU ops and loads.
- src equal to dst is legal: the old value is read in READ, the new value is written in WB.
- Commands are strictly sequential. No forwarding is needed; a write is visible to the next command's READ.
- dbg_data reflects a write on the cycle after the WB edge.
- Reset mid-operation (any state): abort, no write-back, no done, registers cleared.
- cmd_* inputs are ignored when no handshake occurs. cmd_valid may stay high across ops.

Decomposition:
- Package reg_alu_pkg holds:
  - ALU op encodings: ALU_ADD..ALU_PASSB.
  - State enum: IDLE, READ, EXEC, WB.
- Sub-module regfile_param (DATA_W, NREGS): synchronous write, two async read ports plus the debug read port, synchronous reset to 0.
- The ALU is a combinational function or always block inside the top module.

Test Plan:
- Loads 10, 5, 0, 1 into R0..R3; then ALU add R0<=R1+R2 -> done at handshake+3; R0 = 5, zero = 0, overflow = 0.
- Sequence R1<=R2&R3, R3<=R2^R0, R2<=R1-R3 from state {5,5,0,1} -> R1 = 0, R3 = 5, R2 = 0xFFFFFFFB, zero = 0.
- Load R0 = 0xFFFFFFFF, R3 = 1; add R3<=R0+R3 -> R3 = 0, zero = 1, overflow = 0. Load R0 = 0x7FFFFFFF; add R1<=R0+R3 with R3 = 1 -> R1 = 0x80000000, overflow = 1.
- Sub 0x80000000 - 1 -> 0x7FFFFFFF, overflow = 1. SLT of -1 vs 1 -> 1. Pass B and NOR return the expected values.
- Back-to-back with cmd_valid held high: cmd_ready is high only in IDLE; exactly one done per accepted op; a second command reads the first command's result.
- rst asserted during EXEC of a write to R2 = 7 -> no done; R2 and all registers read 0 via dbg_data; cmd_ready = 1 in the cycle after reset deasserts. Rerun with DATA_W = 16, NREGS = 8: sub 0x8000 - 1 -> 0x7FFF, overflow = 1.
